// File: rtl/join24_pkg.sv
// Shared slot-map definitions for the 24-slot operator join: slot count,
// operator base offsets and modulo-24 slot arithmetic.
package join24_pkg;

    localparam int NSLOTS = 24;

    typedef enum logic [1:0] {
        OP_S1 = 2'd0,
        OP_S2 = 2'd1,
        OP_S3 = 2'd2,
        OP_S4 = 2'd3
    } op_e;

    // s2 and s3 are intentionally swapped in the slot layout
    localparam logic [4:0] BASE_S1 = 5'd0;
    localparam logic [4:0] BASE_S2 = 5'd12;
    localparam logic [4:0] BASE_S3 = 5'd6;
    localparam logic [4:0] BASE_S4 = 5'd18;

    function automatic logic [4:0] slot_base(input logic [1:0] op);
        logic [4:0] b;
        case (op_e'(op))
            OP_S1:   b = BASE_S1;
            OP_S2:   b = BASE_S2;
            OP_S3:   b = BASE_S3;
            default: b = BASE_S4;
        endcase
        return b;
    endfunction

    // Both operands are below 32, so the sum never reaches 72 and two
    // conditional subtractions are enough for the modulo.
    function automatic logic [4:0] slot_wrap(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd48)
            s = s - 6'd48;
        else if (s >= 6'd24)
            s = s - 6'd24;
        return s[4:0];
    endfunction

endpackage

// File: rtl/join24.sv
// 24-slot time-multiplexer with a writable shadow bank that is committed to
// the active bank atomically at a frame boundary.
module join24
    import join24_pkg::*;
#(
    parameter int         width = 10,
    parameter logic [4:0] pos0  = 5'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             wr_en,
    input  logic [1:0]       wr_op,
    input  logic [2:0]       wr_ch,
    input  logic [width-1:0] wr_data,
    input  logic             commit,
    output logic [width-1:0] mixed,
    output logic [4:0]       cnt,
    output logic             frame_start,
    output logic             busy
);

    logic [width-1:0] shadow_q [NSLOTS];
    logic [width-1:0] active_q [NSLOTS];

    logic [4:0]       cnt_q, cnt_d;
    logic [width-1:0] mixed_q, mixed_d;
    logic             fs_q, fs_d;
    logic             busy_q, busy_d;

    logic             wrap, swap, wr_ok;
    logic [4:0]       sel, wr_idx;

    always_comb begin
        wrap    = cen && (cnt_q == 5'(NSLOTS - 1));
        swap    = wrap && busy_q;
        cnt_d   = cnt_q;
        fs_d    = fs_q;
        mixed_d = mixed_q;
        sel     = '0;
        if (cen) begin
            cnt_d = wrap ? 5'd0 : cnt_q + 5'd1;
            fs_d  = wrap;
            sel   = slot_wrap(cnt_d, pos0);
            // On the swap edge the output must already show the committed bank
            mixed_d = swap ? shadow_q[sel] : active_q[sel];
        end

        busy_d = busy_q;
        if (swap)
            busy_d = 1'b0;
        else if (commit && !busy_q)
            busy_d = 1'b1;

        wr_ok  = wr_en && (wr_ch <= 3'd5);
        wr_idx = slot_base(wr_op) + 5'(wr_ch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            mixed_q <= '0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < NSLOTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            mixed_q <= mixed_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
            // Swap copies the pre-write shadow; a same-cycle write stays in shadow
            if (swap)
                active_q <= shadow_q;
            if (wr_ok)
                shadow_q[wr_idx] <= wr_data;
        end
    end

    assign mixed       = mixed_q;
    assign cnt         = cnt_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_join24.sv
// Directed bench for join24: one instance with pos0=0 and one with pos0=5
// share all inputs so slot mapping and output offset are checked together.
module tb_join24;

    logic       clk = 1'b0;
    logic       rst, cen, wr_en, commit;
    logic [1:0] wr_op;
    logic [2:0] wr_ch;
    logic [9:0] wr_data;
    logic [9:0] mixed0, mixed5;
    logic [4:0] cnt0, cnt5;
    logic       fs0, fs5, busy0, busy5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    join24 #(.width(10), .pos0(5'd0)) u0 (
        .clk(clk), .rst(rst), .cen(cen), .wr_en(wr_en), .wr_op(wr_op),
        .wr_ch(wr_ch), .wr_data(wr_data), .commit(commit),
        .mixed(mixed0), .cnt(cnt0), .frame_start(fs0), .busy(busy0)
    );

    join24 #(.width(10), .pos0(5'd5)) u5 (
        .clk(clk), .rst(rst), .cen(cen), .wr_en(wr_en), .wr_op(wr_op),
        .wr_ch(wr_ch), .wr_data(wr_data), .commit(commit),
        .mixed(mixed5), .cnt(cnt5), .frame_start(fs5), .busy(busy5)
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] ch;
        logic [9:0] data;
        int         slot;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        commit = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic write(input logic [1:0] op, input logic [2:0] ch, input logic [9:0] d);
        wr_en = 1'b1;
        wr_op = op;
        wr_ch = ch;
        wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic commit_pulse();
        commit = 1'b1;
        cycle();
        commit = 1'b0;
    endtask

    task automatic wait_fs(input string name);
        int n = 0;
        while (fs0 !== 1'b1 && n < 80) begin
            cycle();
            n++;
        end
        chk({name, "_fs"}, 32'(fs0), 32'd1);
    endtask

    task automatic wait_cnt(input string name, input logic [4:0] target);
        int n = 0;
        while (cnt0 !== target && n < 80) begin
            cycle();
            n++;
        end
        chk({name, "_cnt"}, 32'(cnt0), 32'(target));
    endtask

    // Walks one frame starting at cnt=0; slots sa/sb carry da/db, all others 0.
    task automatic scan(input string name, input int sa, input logic [9:0] da,
                        input int sb, input logic [9:0] db);
        logic [9:0] e0, e5;
        int s5;
        chk({name, "_start"}, 32'(cnt0), 32'd0);
        chk({name, "_start5"}, 32'(cnt5), 32'd0);
        for (int i = 0; i < 24; i++) begin
            s5 = (i + 5) % 24;
            e0 = (i == sa) ? da : (i == sb) ? db : 10'd0;
            e5 = (s5 == sa) ? da : (s5 == sb) ? db : 10'd0;
            chk($sformatf("%s_u0_slot%0d", name, i), 32'(mixed0), 32'(e0));
            chk($sformatf("%s_u5_cnt%0d", name, i), 32'(mixed5), 32'(e5));
            cycle();
        end
    endtask

    initial begin
        vecs[0] = '{op: 2'd2, ch: 3'd3, data: 10'h155, slot: 9};
        vecs[1] = '{op: 2'd0, ch: 3'd0, data: 10'h3FF, slot: 0};
        vecs[2] = '{op: 2'd1, ch: 3'd5, data: 10'h0AB, slot: 17};
        vecs[3] = '{op: 2'd3, ch: 3'd2, data: 10'h101, slot: 20};
        vecs[4] = '{op: 2'd2, ch: 3'd0, data: 10'h2AA, slot: 6};
        vecs[5] = '{op: 2'd0, ch: 3'd5, data: 10'h2AA, slot: 5};

        // Reset overrides cen, wr_en and commit
        rst = 1'b1; cen = 1'b1; wr_en = 1'b1; commit = 1'b1;
        wr_op = 2'd0; wr_ch = 3'd1; wr_data = 10'h3FF;
        cycle();
        cycle();
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_mixed", 32'(mixed0), 32'd0);
        chk("rst_fs", 32'(fs0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_busy5", 32'(busy5), 32'd0);
        wr_en = 1'b0; commit = 1'b0;
        rst = 1'b0;

        // Slot mapping and pos0 offset
        foreach (vecs[k]) begin
            do_reset();
            write(vecs[k].op, vecs[k].ch, vecs[k].data);
            commit_pulse();
            chk($sformatf("map%0d_busy_set", k), 32'(busy0), 32'd1);
            wait_fs($sformatf("map%0d", k));
            chk($sformatf("map%0d_busy_clr", k), 32'(busy0), 32'd0);
            chk($sformatf("map%0d_fs5", k), 32'(fs5), 32'd1);
            scan($sformatf("map%0d", k), vecs[k].slot, vecs[k].data, -1, 10'd0);
        end

        // Commit timing: old data persists until the boundary
        do_reset();
        write(2'd0, 3'd0, 10'h011);
        write(2'd3, 3'd5, 10'h033);
        commit_pulse();
        wait_fs("ct_init");
        chk("ct_init_slot0", 32'(mixed0), 32'h011);
        write(2'd0, 3'd0, 10'h022);
        write(2'd3, 3'd5, 10'h044);
        wait_cnt("ct_at10", 5'd10);
        commit_pulse();
        chk("ct_busy_rise", 32'(busy0), 32'd1);
        wait_cnt("ct_at23", 5'd23);
        chk("ct_old23", 32'(mixed0), 32'h033);
        chk("ct_busy23", 32'(busy0), 32'd1);
        cycle();
        chk("ct_cnt0", 32'(cnt0), 32'd0);
        chk("ct_fs", 32'(fs0), 32'd1);
        chk("ct_busy_clr", 32'(busy0), 32'd0);
        chk("ct_new0", 32'(mixed0), 32'h022);
        cycle();
        chk("ct_fs_drop", 32'(fs0), 32'd0);
        wait_cnt("ct_next23", 5'd23);
        chk("ct_new23", 32'(mixed0), 32'h044);

        // Write landing in the swap cycle stays in shadow only
        write(2'd0, 3'd0, 10'h0F0);
        commit_pulse();
        wait_cnt("col_at23", 5'd23);
        chk("col_busy", 32'(busy0), 32'd1);
        write(2'd0, 3'd0, 10'h001);
        chk("col_fs", 32'(fs0), 32'd1);
        chk("col_old", 32'(mixed0), 32'h0F0);
        commit_pulse();
        wait_fs("col_recommit");
        chk("col_new", 32'(mixed0), 32'h001);

        // cen=0 freezes cnt, mixed and frame_start
        cen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk($sformatf("cen_hold%0d_cnt", i), 32'(cnt0), 32'd0);
            chk($sformatf("cen_hold%0d_mixed", i), 32'(mixed0), 32'h001);
            chk($sformatf("cen_hold%0d_fs", i), 32'(fs0), 32'd1);
        end
        cen = 1'b1;
        cycle();
        chk("cen_resume_cnt", 32'(cnt0), 32'd1);
        chk("cen_resume_fs", 32'(fs0), 32'd0);

        // Invalid channels must not disturb any slot
        write(2'd0, 3'd6, 10'h3FF);
        write(2'd3, 3'd7, 10'h155);
        commit_pulse();
        wait_fs("inv");
        scan("inv", 0, 10'h001, 23, 10'h044);

        // Reset while a commit is pending
        commit_pulse();
        wait_cnt("mr_at15", 5'd15);
        chk("mr_busy_pre", 32'(busy0), 32'd1);
        rst = 1'b1;
        cycle();
        chk("mr_cnt", 32'(cnt0), 32'd0);
        chk("mr_mixed", 32'(mixed0), 32'd0);
        chk("mr_mixed5", 32'(mixed5), 32'd0);
        chk("mr_fs", 32'(fs0), 32'd0);
        chk("mr_busy", 32'(busy0), 32'd0);
        rst = 1'b0;
        scan("mr_frame", -1, 10'd0, -1, 10'd0);
        chk("mr_busy_end", 32'(busy0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
